// File: rtl/vec_cmd_sequencer_if.sv
// Host-command, core-issue and result signals of the vector command sequencer.
// slave is the sequencer's view; master is the host/core side.
interface vec_cmd_sequencer_if #(
    parameter int els_p   = 8,
    parameter int vlen_p  = 8,
    parameter int vdw_p   = 8,
    parameter int depth_p = 4
);
    localparam int v_addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_width_lp    = $clog2(depth_p + 1);
    localparam int data_width_lp   = vlen_p * vdw_p;

    logic                       cmd_v_i;
    logic                       cmd_ready_o;
    logic [3:0]                 cmd_op_i;
    logic [v_addr_width_lp-1:0] cmd_addrA_i;
    logic [v_addr_width_lp-1:0] cmd_addrB_i;
    logic [v_addr_width_lp-1:0] cmd_addrD_i;
    logic [vdw_p-1:0]           cmd_scalar_i;
    logic [data_width_lp-1:0]   cmd_w_data_i;

    logic [3:0]                 op_o;
    logic [v_addr_width_lp-1:0] addrA_o;
    logic [v_addr_width_lp-1:0] addrB_o;
    logic [v_addr_width_lp-1:0] addrD_o;
    logic [vdw_p-1:0]           scalar_o;
    logic [data_width_lp-1:0]   w_data_o;
    logic                       v_o;
    logic                       ready_i;
    logic                       core_done_i;
    logic [data_width_lp-1:0]   core_data_i;
    logic                       core_yumi_o;

    logic                       res_v_o;
    logic [data_width_lp-1:0]   res_data_o;
    logic                       res_yumi_i;
    logic                       illegal_o;
    logic [cnt_width_lp-1:0]    count_o;
    logic                       busy_o;

    modport slave (
        input  cmd_v_i, cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrD_i, cmd_scalar_i, cmd_w_data_i,
        input  ready_i, core_done_i, core_data_i, res_yumi_i,
        output cmd_ready_o, op_o, addrA_o, addrB_o, addrD_o, scalar_o, w_data_o, v_o,
        output core_yumi_o, res_v_o, res_data_o, illegal_o, count_o, busy_o
    );

    modport master (
        output cmd_v_i, cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrD_i, cmd_scalar_i, cmd_w_data_i,
        output ready_i, core_done_i, core_data_i, res_yumi_i,
        input  cmd_ready_o, op_o, addrA_o, addrB_o, addrD_o, scalar_o, w_data_o, v_o,
        input  core_yumi_o, res_v_o, res_data_o, illegal_o, count_o, busy_o
    );
endinterface

// File: rtl/vec_cmd_sequencer.sv
// Command FIFO + issue FSM in front of the vector core. The FIFO head drives the
// core fields until retirement; read results land in a one-entry output buffer.
module vec_cmd_sequencer #(
    parameter int els_p   = 8,
    parameter int vlen_p  = 8,
    parameter int vdw_p   = 8,
    parameter int depth_p = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    vec_cmd_sequencer_if.slave   bus
);
    localparam int v_addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_width_lp    = $clog2(depth_p + 1);
    localparam int ptr_width_lp    = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int data_width_lp   = vlen_p * vdw_p;
    localparam logic [3:0] op_read_lp = 4'b1000;

    typedef struct packed {
        logic [3:0]                 op;
        logic [v_addr_width_lp-1:0] addr_a;
        logic [v_addr_width_lp-1:0] addr_b;
        logic [v_addr_width_lp-1:0] addr_d;
        logic [vdw_p-1:0]           scalar;
        logic [data_width_lp-1:0]   w_data;
    } cmd_s;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_e;

    cmd_s                    mem_r [depth_p];
    cmd_s                    cmd_in, head;
    logic [ptr_width_lp-1:0] rd_ptr_r, wr_ptr_r;
    logic [cnt_width_lp-1:0] count_r;
    state_e                  state_r, state_n;
    logic                    push, pop, issue_v, illegal, yumi, capture;
    logic                    res_v_r;
    logic [data_width_lp-1:0] res_data_r;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
            4'b0110, 4'b1000, 4'b1001, 4'b1111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    assign cmd_in = '{op:     bus.cmd_op_i,
                      addr_a: bus.cmd_addrA_i,
                      addr_b: bus.cmd_addrB_i,
                      addr_d: bus.cmd_addrD_i,
                      scalar: bus.cmd_scalar_i,
                      w_data: bus.cmd_w_data_i};
    assign head   = mem_r[rd_ptr_r];

    // Full FIFO never accepts, even when the head retires this cycle.
    assign bus.cmd_ready_o = (count_r < cnt_width_lp'(depth_p));
    assign push            = bus.cmd_v_i & bus.cmd_ready_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < depth_p; i++) mem_r[i] <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= cmd_in;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop) rd_ptr_r <= rd_ptr_r + 1'b1;
            count_r <= count_r + cnt_width_lp'(push) - cnt_width_lp'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= S_IDLE;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        pop     = 1'b0;
        issue_v = 1'b0;
        illegal = 1'b0;
        yumi    = 1'b0;
        capture = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (count_r != '0) begin
                    if (op_legal(head.op)) begin
                        state_n = S_ISSUE;
                    end else begin
                        pop     = 1'b1;
                        illegal = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                issue_v = 1'b1;
                if (bus.ready_i) state_n = S_BUSY;
            end
            S_BUSY: begin
                if (bus.core_done_i) begin
                    if (head.op != op_read_lp) begin
                        pop     = 1'b1;
                        state_n = S_IDLE;
                    end else if (!res_v_r || bus.res_yumi_i) begin
                        // Read retires only when the result buffer has room; the core holds done otherwise.
                        yumi    = 1'b1;
                        capture = 1'b1;
                        pop     = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            res_v_r    <= 1'b0;
            res_data_r <= '0;
        end else begin
            res_v_r <= capture | (res_v_r & ~bus.res_yumi_i);
            if (capture) res_data_r <= bus.core_data_i;
        end
    end

    assign bus.op_o        = head.op;
    assign bus.addrA_o     = head.addr_a;
    assign bus.addrB_o     = head.addr_b;
    assign bus.addrD_o     = head.addr_d;
    assign bus.scalar_o    = head.scalar;
    assign bus.w_data_o    = head.w_data;
    assign bus.v_o         = issue_v;
    assign bus.core_yumi_o = yumi;
    assign bus.illegal_o   = illegal;
    assign bus.res_v_o     = res_v_r;
    assign bus.res_data_o  = res_data_r;
    assign bus.count_o     = count_r;
    assign bus.busy_o      = (state_r != S_IDLE) || (count_r != '0);
endmodule

// File: tb/tb_vec_cmd_sequencer.sv
// Self-checking bench for vec_cmd_sequencer: issue scoreboard, behavioural core
// model and per-scenario tasks.
module tb_vec_cmd_sequencer;
    localparam logic [3:0] OP_RD = 4'b1000;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  a, b, d;
        logic [7:0]  s;
        logic [63:0] w;
    } cmd_t;

    logic clk, rst_n;
    int   checks, errors, iss_cnt, ill_cnt, yumi_cnt, core_lat;
    cmd_t exp_q[$];
    logic [63:0] rd_q[$];
    logic [63:0] res_q[$];
    cmd_t obs;

    vec_cmd_sequencer_if bus ();
    vec_cmd_sequencer dut (.clk_i(clk), .reset_n_i(rst_n), .bus(bus));

    assign obs = {bus.op_o, bus.addrA_o, bus.addrB_o, bus.addrD_o, bus.scalar_o, bus.w_data_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b1000, 4'b1001, 4'b1111};
    endfunction

    // Core model: handshake when v_o & ready_i, raise done core_lat cycles later,
    // hold done on a read until core_yumi_o. Also scores issued fields.
    initial begin
        bit   busy_m, acc_pending, cur_read;
        int   cnt;
        cmd_t cur;
        busy_m = 0; acc_pending = 0; cur_read = 0; cnt = 0; cur = '0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                bus.core_done_i = 1'b0; busy_m = 0; acc_pending = 0;
                continue;
            end
            if (acc_pending) begin
                bus.core_done_i = 1'b0; acc_pending = 0; busy_m = 0;
            end
            if (bus.illegal_o) ill_cnt++;
            if (bus.v_o && bus.ready_i) begin
                iss_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: got op %b, expected no issue", bus.op_o);
                    cur = obs;
                end else begin
                    cur = exp_q.pop_front();
                    if (obs !== cur) begin
                        errors++;
                        $display("FAIL issue_fields: got %h expected %h", obs, cur);
                    end
                end
                cur_read = (obs.op == OP_RD);
                cnt      = core_lat;
                busy_m   = 1;
            end else if (busy_m) begin
                checks++;
                if (obs !== cur) begin
                    errors++;
                    $display("FAIL field_stable: got %h expected %h", obs, cur);
                end
                if (!bus.core_done_i) begin
                    cnt--;
                    if (cnt <= 0) begin
                        bus.core_done_i = 1'b1;
                        if (cur_read) bus.core_data_i = (rd_q.size() != 0) ? rd_q.pop_front() : 64'h0;
                    end
                end
            end
            #1;
            if (bus.core_done_i) acc_pending = !cur_read || bus.core_yumi_o;
            if (bus.core_yumi_o) yumi_cnt++;
        end
    end

    // Called at a negedge; returns at the negedge after acceptance with cmd_v_i low.
    task automatic push_cmd(input logic [3:0] op, input logic [2:0] a, b, d,
                            input logic [7:0] s, input logic [63:0] w, output logic [2:0] cnt_at);
        int n = 0;
        bus.cmd_v_i = 1'b1; bus.cmd_op_i = op; bus.cmd_addrA_i = a; bus.cmd_addrB_i = b;
        bus.cmd_addrD_i = d; bus.cmd_scalar_i = s; bus.cmd_w_data_i = w;
        while (!bus.cmd_ready_o && n < 500) begin @(negedge clk); n++; end
        cnt_at = bus.count_o;
        checks++;
        if (!bus.cmd_ready_o) begin
            errors++;
            $display("FAIL push_timeout: got cmd_ready_o=0 expected 1 for op %b", op);
        end else if (legal(op)) begin
            exp_q.push_back({op, a, b, d, s, w});
        end
        @(negedge clk);
        bus.cmd_v_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((bus.busy_o || exp_q.size() != 0 || bus.core_done_i) && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (bus.busy_o || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_idle: got busy=%b pending=%0d expected idle", tag, bus.busy_o, exp_q.size());
        end
    endtask

    task automatic check_cleared(input string tag);
        checks++;
        if ({bus.v_o, bus.core_yumi_o, bus.res_v_o, bus.illegal_o, bus.busy_o} !== 5'b0) begin
            errors++;
            $display("FAIL %s_ctrl: got v/yumi/res_v/illegal/busy=%b expected 00000", tag,
                     {bus.v_o, bus.core_yumi_o, bus.res_v_o, bus.illegal_o, bus.busy_o});
        end
        checks++;
        if (bus.count_o !== 3'd0) begin errors++; $display("FAIL %s_count: got %0d expected 0", tag, bus.count_o); end
        checks++;
        if (bus.cmd_ready_o !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b expected 1", tag, bus.cmd_ready_o); end
        checks++;
        if (bus.res_data_o !== 64'h0) begin errors++; $display("FAIL %s_res_data: got %h expected 0", tag, bus.res_data_o); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_fields: got %h expected 0", obs); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [2:0] c;
        int n = 0;
        bus.ready_i = 1'b1; core_lat = 5;
        push_cmd(4'b0000, 3'd1, 3'd2, 3'd3, 8'h11, 64'h0, c);
        checks++;
        if ({bus.v_o, bus.count_o} !== {1'b0, 3'd1}) begin
            errors++; $display("FAIL add_t1: got v=%b count=%0d expected v=0 count=1", bus.v_o, bus.count_o);
        end
        @(negedge clk);
        checks++;
        if (bus.v_o !== 1'b1) begin errors++; $display("FAIL add_v_rise: got %b expected 1", bus.v_o); end
        @(negedge clk);
        checks++;
        if ({bus.v_o, bus.busy_o} !== 2'b01) begin
            errors++; $display("FAIL add_v_fall: got v=%b busy=%b expected v=0 busy=1", bus.v_o, bus.busy_o);
        end
        while (bus.count_o != 3'd0 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n !== 5) begin errors++; $display("FAIL add_retire_cycles: got %0d expected 5", n); end
        checks++;
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL add_busy_fall: got %b expected 0", bus.busy_o); end
        wait_idle("add");
    endtask

    task automatic test_fill();
        logic [2:0] c;
        int iss0 = iss_cnt;
        bus.ready_i = 1'b0; core_lat = 2;
        for (int i = 0; i < 4; i++) push_cmd(4'(i == 3 ? 4 : i), 3'(i), 3'(i + 1), 3'(i + 2), 8'(8'hA0 + i), {8{8'(i)}}, c);
        checks++;
        if ({bus.cmd_ready_o, bus.count_o} !== {1'b0, 3'd4}) begin
            errors++; $display("FAIL fill_full: got ready=%b count=%0d expected ready=0 count=4", bus.cmd_ready_o, bus.count_o);
        end
        bus.ready_i = 1'b1;
        push_cmd(4'b0101, 3'd7, 3'd6, 3'd5, 8'hFF, 64'hCAFE_F00D_1234_5678, c);
        checks++;
        if (c !== 3'd3) begin errors++; $display("FAIL fill_fifth_accept: got count %0d expected 3", c); end
        wait_idle("fill");
        checks++;
        if (iss_cnt - iss0 !== 5) begin errors++; $display("FAIL fill_issues: got %0d expected 5", iss_cnt - iss0); end
    endtask

    task automatic test_read();
        logic [2:0] c;
        int y0 = yumi_cnt;
        int n = 0;
        bus.ready_i = 1'b1; core_lat = 3;
        rd_q.push_back(64'h0807060504030201); res_q.push_back(64'h0807060504030201);
        push_cmd(OP_RD, 3'd4, 3'd0, 3'd5, 8'h0, 64'h0, c);
        while (!bus.res_v_o && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (bus.res_data_o !== res_q[0] || bus.res_v_o !== 1'b1) begin
            errors++; $display("FAIL read1_data: got v=%b %h expected v=1 %h", bus.res_v_o, bus.res_data_o, res_q[0]);
        end
        checks++;
        if (yumi_cnt - y0 !== 1) begin errors++; $display("FAIL read1_yumi: got %0d expected 1", yumi_cnt - y0); end
        rd_q.push_back(64'h1122334455667788); res_q.push_back(64'h1122334455667788);
        push_cmd(OP_RD, 3'd6, 3'd0, 3'd1, 8'h0, 64'h0, c);
        repeat (15) @(negedge clk);
        checks++;
        if (yumi_cnt - y0 !== 1) begin errors++; $display("FAIL read2_stall_yumi: got %0d expected 1", yumi_cnt - y0); end
        checks++;
        if ({bus.busy_o, bus.v_o, bus.count_o, bus.core_done_i} !== {1'b1, 1'b0, 3'd1, 1'b1}) begin
            errors++; $display("FAIL read2_stall_state: got busy=%b v=%b count=%0d done=%b expected 1 0 1 1",
                               bus.busy_o, bus.v_o, bus.count_o, bus.core_done_i);
        end
        checks++;
        if (bus.res_data_o !== res_q[0]) begin errors++; $display("FAIL read2_stall_data: got %h expected %h", bus.res_data_o, res_q[0]); end
        void'(res_q.pop_front());
        bus.res_yumi_i = 1'b1;
        @(negedge clk);
        bus.res_yumi_i = 1'b0;
        checks++;
        if ({bus.res_v_o, bus.count_o} !== {1'b1, 3'd0} || yumi_cnt - y0 !== 2) begin
            errors++; $display("FAIL read2_capture: got res_v=%b count=%0d yumis=%0d expected 1 0 2",
                               bus.res_v_o, bus.count_o, yumi_cnt - y0);
        end
        checks++;
        if (bus.res_data_o !== res_q[0]) begin errors++; $display("FAIL read2_data: got %h expected %h", bus.res_data_o, res_q[0]); end
        bus.res_yumi_i = 1'b1;
        @(negedge clk);
        bus.res_yumi_i = 1'b0;
        checks++;
        if (bus.res_v_o !== 1'b0 || bus.res_data_o !== res_q[0]) begin
            errors++; $display("FAIL read_drain_hold: got v=%b %h expected v=0 %h", bus.res_v_o, bus.res_data_o, res_q[0]);
        end
        void'(res_q.pop_front());
        wait_idle("read");
    endtask

    task automatic test_illegal();
        logic [2:0] c;
        int i0 = ill_cnt;
        int s0 = iss_cnt;
        bus.ready_i = 1'b1; core_lat = 2;
        push_cmd(4'b0011, 3'd1, 3'd1, 3'd1, 8'h01, 64'h1, c);
        push_cmd(4'b0110, 3'd2, 3'd3, 3'd4, 8'h02, 64'h2, c);
        push_cmd(4'b1110, 3'd5, 3'd5, 3'd5, 8'h03, 64'h3, c);
        wait_idle("illegal");
        checks++;
        if (ill_cnt - i0 !== 2) begin errors++; $display("FAIL illegal_pulses: got %0d expected 2", ill_cnt - i0); end
        checks++;
        if (iss_cnt - s0 !== 1) begin errors++; $display("FAIL illegal_issues: got %0d expected 1", iss_cnt - s0); end
    endtask

    task automatic test_matrix_write();
        logic [2:0] c;
        int n = 0;
        bus.ready_i = 1'b1; core_lat = 4;
        push_cmd(4'b1111, 3'd1, 3'd2, 3'd3, 8'h5A, 64'hDEAD_BEEF_0000_0001, c);
        do begin @(negedge clk); #3; n++; end while (!bus.core_done_i && n < 50);
        checks++;
        if (!bus.core_done_i) begin errors++; $display("FAIL mm_done_timeout: got done=0 expected 1"); end
        bus.cmd_v_i = 1'b1; bus.cmd_op_i = 4'b1001; bus.cmd_addrA_i = 3'd0; bus.cmd_addrB_i = 3'd0;
        bus.cmd_addrD_i = 3'd6; bus.cmd_scalar_i = 8'h00; bus.cmd_w_data_i = 64'hA5A5_5A5A_0F0F_F0F0;
        checks++;
        if ({bus.cmd_ready_o, bus.count_o} !== {1'b1, 3'd1}) begin
            errors++; $display("FAIL mm_pre: got ready=%b count=%0d expected ready=1 count=1", bus.cmd_ready_o, bus.count_o);
        end
        exp_q.push_back({4'b1001, 3'd0, 3'd0, 3'd6, 8'h00, 64'hA5A5_5A5A_0F0F_F0F0});
        @(negedge clk);
        bus.cmd_v_i = 1'b0;
        checks++;
        if (bus.count_o !== 3'd1) begin errors++; $display("FAIL mm_count_const: got %0d expected 1", bus.count_o); end
        checks++;
        if ({bus.op_o, bus.addrD_o} !== {4'b1001, 3'd6}) begin
            errors++; $display("FAIL mm_next_head: got op=%b D=%0d expected op=1001 D=6", bus.op_o, bus.addrD_o);
        end
        wait_idle("mm");
    endtask

    task automatic test_reset_mid_busy();
        logic [2:0] c;
        int s0;
        bus.ready_i = 1'b1; core_lat = 20;
        push_cmd(4'b0000, 3'd1, 3'd1, 3'd1, 8'h01, 64'h1, c);
        push_cmd(4'b0001, 3'd2, 3'd2, 3'd2, 8'h02, 64'h2, c);
        push_cmd(4'b0010, 3'd3, 3'd3, 3'd3, 8'h03, 64'h3, c);
        push_cmd(4'b0100, 3'd4, 3'd4, 3'd4, 8'h04, 64'h4, c);
        checks++;
        if ({bus.busy_o, bus.v_o, bus.count_o} !== {1'b1, 1'b0, 3'd4}) begin
            errors++; $display("FAIL rst_pre: got busy=%b v=%b count=%0d expected 1 0 4", bus.busy_o, bus.v_o, bus.count_o);
        end
        s0 = iss_cnt;
        rst_n = 1'b0;
        #1;
        check_cleared("rst_async");
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL rst_async_fields: got %h expected 0", obs); end
        exp_q.delete(); rd_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (iss_cnt !== s0 || bus.busy_o !== 1'b0 || bus.count_o !== 3'd0) begin
            errors++; $display("FAIL rst_no_reissue: got issues=%0d busy=%b count=%0d expected %0d 0 0",
                               iss_cnt, bus.busy_o, bus.count_o, s0);
        end
    endtask

    initial begin
        checks = 0; errors = 0; iss_cnt = 0; ill_cnt = 0; yumi_cnt = 0; core_lat = 1;
        rst_n = 1'b0;
        bus.cmd_v_i = 1'b0; bus.cmd_op_i = '0; bus.cmd_addrA_i = '0; bus.cmd_addrB_i = '0;
        bus.cmd_addrD_i = '0; bus.cmd_scalar_i = '0; bus.cmd_w_data_i = '0;
        bus.ready_i = 1'b0; bus.core_done_i = 1'b0; bus.core_data_i = '0; bus.res_yumi_i = 1'b0;
        test_reset();
        test_add();
        test_fill();
        test_read();
        test_illegal();
        test_matrix_write();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
